// File: rtl/clk_switch_ctrl.sv
// Break-before-make controller for a glitchless NUM_CLOCKS-way clock mux, driven by synchronised gating-cell acks.
// Define CLK_SWITCH_FALLBACK_EN to return to the previous source when a newly selected one fails to start.
module clk_switch_ctrl #(
  parameter int NUM_CLOCKS     = 4,
  parameter int SEL_W          = $clog2(NUM_CLOCKS),
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DEFAULT_SEL    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [SEL_W-1:0]      req_sel,
  output logic                  req_ready,
  output logic [NUM_CLOCKS-1:0] ena_out,
  input  logic [NUM_CLOCKS-1:0] ena_ack,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout,
  output logic                  err_range,
  output logic                  fault
);

  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW1 = SEL_W + 1;
  localparam logic [SEL_W-1:0]      DEF_SEL   = SEL_W'(DEFAULT_SEL);
  localparam logic [NUM_CLOCKS-1:0] DEF_ENA   = NUM_CLOCKS'(1) << DEFAULT_SEL;
  localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_W:0]        SEL_LIMIT = SW1'(NUM_CLOCKS);

  typedef enum logic [1:0] {ON_WAIT, IDLE, OFF_WAIT, FAULT} state_t;

  state_t                state, state_nxt;
  logic [SEL_W-1:0]      target, target_nxt;
  logic [SEL_W-1:0]      cur_sel_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic [NUM_CLOCKS-1:0] ena_nxt;
  logic                  done_nxt, err_timeout_nxt, err_range_nxt;
`ifdef CLK_SWITCH_FALLBACK_EN
  logic [SEL_W-1:0]      prev, prev_nxt;
  logic                  fb_flag, fb_flag_nxt;
`endif

  logic [NUM_CLOCKS-1:0] ack_sync [SYNC_STAGES];
  logic [NUM_CLOCKS-1:0] ack_s;
  logic                  xfer, sel_bad, sel_same, off_ok, on_ok, tmo;

  // Each ack bit comes from a different clock domain; only the last stage is trusted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) ack_sync[i] <= '0;
    end else begin
      ack_sync[0] <= ena_ack;
      for (int i = 1; i < SYNC_STAGES; i++) ack_sync[i] <= ack_sync[i-1];
    end
  end

  assign ack_s     = ack_sync[SYNC_STAGES-1];
  assign req_ready = (state == IDLE) || (state == FAULT);
  assign busy      = (state == ON_WAIT) || (state == OFF_WAIT);
  assign fault     = (state == FAULT);
  assign xfer      = req_valid && req_ready;
  assign sel_bad   = {1'b0, req_sel} >= SEL_LIMIT;
  assign sel_same  = (state == IDLE) && (req_sel == cur_sel);
  assign off_ok    = (ack_s == '0);
  assign on_ok     = (ack_s == (NUM_CLOCKS'(1) << target));
  assign tmo       = (timer == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ON_WAIT;
      target      <= DEF_SEL;
      cur_sel     <= DEF_SEL;
      timer       <= '0;
      ena_out     <= DEF_ENA;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_range   <= 1'b0;
`ifdef CLK_SWITCH_FALLBACK_EN
      prev        <= DEF_SEL;
      fb_flag     <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      target      <= target_nxt;
      cur_sel     <= cur_sel_nxt;
      timer       <= timer_nxt;
      ena_out     <= ena_nxt;
      done        <= done_nxt;
      err_timeout <= err_timeout_nxt;
      err_range   <= err_range_nxt;
`ifdef CLK_SWITCH_FALLBACK_EN
      prev        <= prev_nxt;
      fb_flag     <= fb_flag_nxt;
`endif
    end
  end

  // An exit condition seen on the same edge as the timeout always wins.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FAULT: begin
        if (xfer && !sel_bad && !sel_same) state_nxt = OFF_WAIT;
      end
      OFF_WAIT: begin
        if (off_ok)   state_nxt = ON_WAIT;
        else if (tmo) state_nxt = FAULT;
      end
      ON_WAIT: begin
        if (on_ok) begin
          state_nxt = IDLE;
        end else if (tmo) begin
`ifdef CLK_SWITCH_FALLBACK_EN
          state_nxt = fb_flag ? FAULT : OFF_WAIT;
`else
          state_nxt = FAULT;
`endif
        end
      end
      default: state_nxt = ON_WAIT;
    endcase
  end

  always_comb begin
    target_nxt      = target;
    cur_sel_nxt     = cur_sel;
    ena_nxt         = ena_out;
    done_nxt        = 1'b0;
    err_timeout_nxt = 1'b0;
    err_range_nxt   = 1'b0;
`ifdef CLK_SWITCH_FALLBACK_EN
    prev_nxt        = prev;
    fb_flag_nxt     = fb_flag;
`endif
    if (state_nxt != state)                     timer_nxt = '0;
    else if (state == ON_WAIT || state == OFF_WAIT) timer_nxt = timer + TW'(1);
    else                                        timer_nxt = '0;

    case (state)
      IDLE, FAULT: begin
        if (xfer) begin
          if (sel_bad) begin
            err_range_nxt = 1'b1;
          end else if (sel_same) begin
            done_nxt = 1'b1;
          end else begin
            target_nxt = req_sel;
            ena_nxt    = '0;
`ifdef CLK_SWITCH_FALLBACK_EN
            prev_nxt    = cur_sel;
            fb_flag_nxt = 1'b0;
`endif
          end
        end
      end
      OFF_WAIT: begin
        if (off_ok) begin
          ena_nxt = NUM_CLOCKS'(1) << target;
        end else if (tmo) begin
          err_timeout_nxt = 1'b1;
          ena_nxt         = '0;
`ifdef CLK_SWITCH_FALLBACK_EN
          fb_flag_nxt = 1'b0;
`endif
        end
      end
      ON_WAIT: begin
        if (on_ok) begin
          cur_sel_nxt = target;
          done_nxt    = 1'b1;
`ifdef CLK_SWITCH_FALLBACK_EN
          fb_flag_nxt = 1'b0;
`endif
        end else if (tmo) begin
          err_timeout_nxt = 1'b1;
          ena_nxt         = '0;
`ifdef CLK_SWITCH_FALLBACK_EN
          // Only one retry on the previous source; a second failure parks in FAULT.
          if (!fb_flag) begin
            target_nxt  = prev;
            fb_flag_nxt = 1'b1;
          end else begin
            fb_flag_nxt = 1'b0;
          end
`endif
        end
      end
      default: ena_nxt = '0;
    endcase
  end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed, scoreboard-based bench for clk_switch_ctrl; gating cells are modelled as acks mirroring ena_out
// with per-bit stuck-high/stuck-low overrides.
module tb_clk_switch_ctrl;

  localparam int NC  = 4;
  localparam int SW  = 3;
  localparam int SS  = 2;
  localparam int TMO = 16;

  localparam logic [2:0] EV_NONE = 3'b000;
  localparam logic [2:0] EV_DONE = 3'b100;
  localparam logic [2:0] EV_TMO  = 3'b010;
  localparam logic [2:0] EV_RNG  = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [2:0] sel;
    int         at;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [SW-1:0] req_sel = '0;
  logic          req_ready;
  logic [NC-1:0] ena_out;
  logic [NC-1:0] ena_ack;
  logic [SW-1:0] cur_sel;
  logic          busy, done, err_timeout, err_range, fault;
  logic [NC-1:0] force_high = '0;
  logic [NC-1:0] force_low  = '0;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  ev_t sb[$];

  clk_switch_ctrl #(
    .NUM_CLOCKS(NC), .SEL_W(SW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO), .DEFAULT_SEL(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
    .ena_out(ena_out), .ena_ack(ena_ack), .cur_sel(cur_sel), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_range(err_range), .fault(fault)
  );

  assign ena_ack = (ena_out & ~force_low) | force_high;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request at a negedge; the transfer happens on the following posedge.
  task automatic apply_stimulus(input logic [2:0] sel, input logic [2:0] kind,
                                input logic [2:0] exp_sel, input int lat);
    ev_t e;
    @(negedge clk);
    check_output("req_ready_before_xfer", 32'(req_ready), 32'd1);
    if (kind != EV_NONE) begin
      e.kind = kind;
      e.sel  = exp_sel;
      e.at   = (lat < 0) ? -1 : cyc + 1 + lat;
      sb.push_back(e);
    end
    req_valid = 1'b1;
    req_sel   = sel;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic expect_event(input logic [2:0] kind, input logic [2:0] exp_sel);
    ev_t e;
    e.kind = kind;
    e.sel  = exp_sel;
    e.at   = -1;
    sb.push_back(e);
  endtask

  task automatic wait_sb(input int max_cyc, input string tag);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Scoreboard consumer and one-hot enable monitor.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst_n) begin
      check_output("ena_onehot0", 32'($onehot0(ena_out)), 32'd1);
      if (done || err_timeout || err_range) begin
        if (sb.size() == 0) begin
          check_output("unexpected_event", 32'({done, err_timeout, err_range}), 32'd0);
        end else begin
          e = sb.pop_front();
          check_output("event_kind", 32'({done, err_timeout, err_range}), 32'(e.kind));
          check_output("event_cur_sel", 32'(cur_sel), 32'(e.sel));
          if (e.at >= 0) check_output("event_cycle", 32'(cyc), 32'(e.at));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset values
    #12;
    check_output("rst_ena_out", 32'(ena_out), 32'h1);
    check_output("rst_cur_sel", 32'(cur_sel), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd1);
    check_output("rst_req_ready", 32'(req_ready), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_fault", 32'(fault), 32'd0);
    expect_event(EV_DONE, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sb(2 * SS + 4, "rst_done_pulse");
    check_output("post_rst_ready", 32'(req_ready), 32'd1);
    check_output("post_rst_ena", 32'(ena_out), 32'h1);

    // Normal switch 0 -> 2
    apply_stimulus(3'd2, EV_DONE, 3'd2, 2 * SS + 2);
    check_output("sw_ena_off", 32'(ena_out), 32'h0);
    check_output("sw_busy", 32'(busy), 32'd1);
    check_output("sw_not_ready", 32'(req_ready), 32'd0);
    wait_sb(20, "sw_done");
    check_output("sw_cur_sel", 32'(cur_sel), 32'd2);
    check_output("sw_ena_on", 32'(ena_out), 32'h4);

    // Out-of-range request, then same-source no-op
    apply_stimulus(3'd5, EV_RNG, 3'd2, 0);
    wait_sb(4, "rng_pulse");
    check_output("rng_ena", 32'(ena_out), 32'h4);
    check_output("rng_cur_sel", 32'(cur_sel), 32'd2);
    check_output("rng_ready", 32'(req_ready), 32'd1);
    apply_stimulus(3'd2, EV_DONE, 3'd2, 0);
    wait_sb(4, "noop_done");
    check_output("noop_ena", 32'(ena_out), 32'h4);
    check_output("noop_busy", 32'(busy), 32'd0);

    // Old source stuck on: OFF_WAIT timeout into FAULT
    force_high = 4'b0100;
    apply_stimulus(3'd1, EV_TMO, 3'd2, TMO);
    wait_sb(TMO + 8, "stuck_timeout");
    check_output("stuck_fault", 32'(fault), 32'd1);
    check_output("stuck_ena", 32'(ena_out), 32'h0);
    check_output("stuck_ready", 32'(req_ready), 32'd1);
    check_output("stuck_cur_sel", 32'(cur_sel), 32'd2);

    // Recovery from FAULT with acks released
    force_high = '0;
    repeat (4) @(posedge clk);
    apply_stimulus(3'd3, EV_DONE, 3'd3, -1);
    wait_sb(20, "recover_done");
    check_output("recover_fault", 32'(fault), 32'd0);
    check_output("recover_ena", 32'(ena_out), 32'h8);

    // Dead new source: 3 -> 1 normally, then 1 -> 3 with ack[3] stuck low
    apply_stimulus(3'd1, EV_DONE, 3'd1, 2 * SS + 2);
    wait_sb(20, "to1_done");
    force_low = 4'b1000;
    apply_stimulus(3'd3, EV_TMO, 3'd1, SS + 1 + TMO);
`ifdef CLK_SWITCH_FALLBACK_EN
    expect_event(EV_DONE, 3'd1);
    wait_sb(3 * TMO, "dead_fallback");
    check_output("dead_cur_sel", 32'(cur_sel), 32'd1);
    check_output("dead_ena", 32'(ena_out), 32'h2);
    check_output("dead_fault", 32'(fault), 32'd0);
`else
    wait_sb(3 * TMO, "dead_timeout");
    check_output("dead_cur_sel", 32'(cur_sel), 32'd1);
    check_output("dead_ena", 32'(ena_out), 32'h0);
    check_output("dead_fault", 32'(fault), 32'd1);
`endif
    force_low = '0;

    // Reset asserted while in ON_WAIT
    apply_stimulus(3'd2, EV_NONE, 3'd0, -1);
    repeat (3) @(posedge clk);
    #2;
    check_output("mid_busy", 32'(busy), 32'd1);
    check_output("mid_ena", 32'(ena_out), 32'h4);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_ena", 32'(ena_out), 32'h1);
    check_output("mid_rst_cur_sel", 32'(cur_sel), 32'd0);
    check_output("mid_rst_busy", 32'(busy), 32'd1);
    check_output("mid_rst_ready", 32'(req_ready), 32'd0);
    check_output("mid_rst_fault", 32'(fault), 32'd0);
    expect_event(EV_DONE, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sb(2 * SS + 4, "mid_rst_restore");
    check_output("mid_restore_ena", 32'(ena_out), 32'h1);
    check_output("mid_restore_ready", 32'(req_ready), 32'd1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
